// File: rtl/tdc_phase_sampler.sv
// -----------------------------------------------------------------------------
// tdc_phase_sampler
//
// Receive side of the ring-oscillator phase bus in the TDC path. The raw tap
// vector is captured on the reference clock, passed through a second
// synchroniser flop, decoded from its Johnson-style pattern into a fractional
// DCO phase (0..2*N_TAPS-1), and turned into a per-sample phase delta and a
// wrapping accumulated phase for the ADPLL loop filter.
//
// Pipeline (advances every cycle, valid bit travels with the data):
//   p1 : raw capture of osc_phases
//   p2 : second synchroniser flop
//   p3 : popcount decode + Johnson code check
//   p4 : delta / accumulate / output registers
// A sample captured at edge n is presented with valid=1 after edge n+3.
//
// Optional build macro:
//   TDC_ERR_HOLD_EN - samples failing the code check leave phase and the
//                     delta reference untouched (delta=0, accumulator held);
//                     valid, code_err and err_cnt still report them.
//
// Ports:
//   clk         in   reference (FREF) sampling clock
//   rst_n       in   asynchronous active-low reset
//   en          in   sampler enable, synchronous to clk
//   osc_phases  in   [N_TAPS]   asynchronous ring-oscillator taps
//   phase       out  [PH_W]     decoded fractional phase
//   phase_delta out  [PH_W]     (phase - previous phase) mod 2^PH_W
//   phase_acc   out  [ACC_W]    running sum of phase_delta, wrapping
//   valid       out  1          outputs updated this cycle
//   code_err    out  1          current sample failed the code check
//   err_cnt     out  [ERRCNT_W] saturating count of erroneous samples
// -----------------------------------------------------------------------------
module tdc_phase_sampler #(
  parameter int N_TAPS   = 32,
  parameter int PH_W     = 6,
  parameter int ACC_W    = 16,
  parameter int ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [N_TAPS-1:0]   osc_phases,
  output logic [PH_W-1:0]     phase,
  output logic [PH_W-1:0]     phase_delta,
  output logic [ACC_W-1:0]    phase_acc,
  output logic                valid,
  output logic                code_err,
  output logic [ERRCNT_W-1:0] err_cnt
);

  localparam int CNT_W = $clog2(N_TAPS + 1);

  // Number of set taps; a single-bit bubble only shifts the count by one,
  // so the decoded phase degrades gracefully instead of jumping.
  function automatic logic [CNT_W-1:0] popcount(input logic [N_TAPS-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_TAPS; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  // First half-period: ones fill from tap 0 upward (phase = k).
  // Second half-period: ones drain from tap 0 upward (phase = 2N - k).
  function automatic logic [PH_W-1:0] decode_phase(input logic [N_TAPS-1:0] v);
    logic [CNT_W-1:0] k;
    k = popcount(v);
    if (v[0] || (k == '0)) begin
      return PH_W'(k);
    end
    return PH_W'(2 * N_TAPS - int'(k));
  endfunction

  // A legal Johnson word has at most one boundary between runs of ones
  // and zeros along the tap chain.
  function automatic logic code_bad(input logic [N_TAPS-1:0] v);
    int t;
    t = 0;
    for (int i = 0; i < N_TAPS - 1; i++) begin
      if (v[i] != v[i+1]) begin
        t++;
      end
    end
    return (t > 1);
  endfunction

  function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] c);
    if (&c) begin
      return c;
    end
    return c + ERRCNT_W'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Pipeline state
  // ---------------------------------------------------------------------------
  logic [N_TAPS-1:0]   samp_p1_q, samp_p1_d;
  logic                vld_p1_q,  vld_p1_d;
  logic [N_TAPS-1:0]   sync_p2_q, sync_p2_d;
  logic                vld_p2_q,  vld_p2_d;
  logic [PH_W-1:0]     phase_p3_q, phase_p3_d;
  logic                err_p3_q,   err_p3_d;
  logic                vld_p3_q,   vld_p3_d;

  // phase_q doubles as the delta reference: both only move on accepted samples.
  logic [PH_W-1:0]     phase_q,    phase_d;
  logic [PH_W-1:0]     delta_q,    delta_d;
  logic [ACC_W-1:0]    acc_q,      acc_d;
  logic                valid_q,    valid_d;
  logic                code_err_q, code_err_d;
  logic [ERRCNT_W-1:0] err_cnt_q,  err_cnt_d;
  logic                first_q,    first_d;

  logic                hold_smp;
  logic [PH_W-1:0]     delta_new;

`ifdef TDC_ERR_HOLD_EN
  assign hold_smp = err_p3_q;
`else
  assign hold_smp = 1'b0;
`endif

  always_comb begin
    // p1: raw capture, tagged with the enable seen on the same edge
    samp_p1_d  = osc_phases;
    vld_p1_d   = en;

    // p2: second synchroniser flop
    sync_p2_d  = samp_p1_q;
    vld_p2_d   = vld_p1_q;

    // p3: decode and code check
    phase_p3_d = decode_phase(sync_p2_q);
    err_p3_d   = code_bad(sync_p2_q);
    vld_p3_d   = vld_p2_q;

    // p4: delta / accumulate / outputs
    phase_d    = phase_q;
    delta_d    = delta_q;
    acc_d      = acc_q;
    valid_d    = 1'b0;
    code_err_d = code_err_q;
    err_cnt_d  = err_cnt_q;
    first_d    = first_q;
    delta_new  = phase_p3_q - phase_q;

    if (vld_p3_q) begin
      valid_d    = 1'b1;
      code_err_d = err_p3_q;
      if (err_p3_q) begin
        err_cnt_d = sat_inc(err_cnt_q);
      end
      if (hold_smp) begin
        // Rejected sample: no reference yet established from it, so a
        // pending first-sample condition stays armed.
        delta_d = '0;
      end else begin
        phase_d = phase_p3_q;
        first_d = 1'b0;
        if (first_q) begin
          delta_d = '0;
        end else begin
          delta_d = delta_new;
          acc_d   = acc_q + ACC_W'(delta_new);
        end
      end
    end else begin
      // Any gap in the valid stream means en dropped; the next valid sample
      // has no trustworthy predecessor.
      first_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_p1_q  <= '0;
      vld_p1_q   <= 1'b0;
      sync_p2_q  <= '0;
      vld_p2_q   <= 1'b0;
      phase_p3_q <= '0;
      err_p3_q   <= 1'b0;
      vld_p3_q   <= 1'b0;
      phase_q    <= '0;
      delta_q    <= '0;
      acc_q      <= '0;
      valid_q    <= 1'b0;
      code_err_q <= 1'b0;
      err_cnt_q  <= '0;
      first_q    <= 1'b1;
    end else begin
      samp_p1_q  <= samp_p1_d;
      vld_p1_q   <= vld_p1_d;
      sync_p2_q  <= sync_p2_d;
      vld_p2_q   <= vld_p2_d;
      phase_p3_q <= phase_p3_d;
      err_p3_q   <= err_p3_d;
      vld_p3_q   <= vld_p3_d;
      phase_q    <= phase_d;
      delta_q    <= delta_d;
      acc_q      <= acc_d;
      valid_q    <= valid_d;
      code_err_q <= code_err_d;
      err_cnt_q  <= err_cnt_d;
      first_q    <= first_d;
    end
  end

  assign phase       = phase_q;
  assign phase_delta = delta_q;
  assign phase_acc   = acc_q;
  assign valid       = valid_q;
  assign code_err    = code_err_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_tdc_phase_sampler.sv
// -----------------------------------------------------------------------------
// tb_tdc_phase_sampler
//
// Directed bench for tdc_phase_sampler. Inputs change 1 ns after a rising
// edge and outputs are sampled at the same point, so each tick() advances the
// design by exactly one edge. Expected values are hand-derived from the
// Johnson decode rule; TDC_ERR_HOLD_EN selects the alternate expectations.
// -----------------------------------------------------------------------------
module tb_tdc_phase_sampler;

  localparam int N_TAPS   = 32;
  localparam int PH_W     = 6;
  localparam int ACC_W    = 16;
  localparam int ERRCNT_W = 8;
  localparam int N_STEPS  = 65536 / 3 + 1;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                en;
  logic [N_TAPS-1:0]   osc_phases;
  logic [PH_W-1:0]     phase;
  logic [PH_W-1:0]     phase_delta;
  logic [ACC_W-1:0]    phase_acc;
  logic                valid;
  logic                code_err;
  logic [ERRCNT_W-1:0] err_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tdc_phase_sampler #(
    .N_TAPS   (N_TAPS),
    .PH_W     (PH_W),
    .ACC_W    (ACC_W),
    .ERRCNT_W (ERRCNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .osc_phases  (osc_phases),
    .phase       (phase),
    .phase_delta (phase_delta),
    .phase_acc   (phase_acc),
    .valid       (valid),
    .code_err    (code_err),
    .err_cnt     (err_cnt)
  );

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Johnson code word for a phase value (inverse of the decode rule).
  function automatic logic [31:0] enc(input int p);
    logic [31:0] one;
    one = 32'h1;
    if (p == 0)  return 32'h0;
    if (p == 32) return 32'hFFFF_FFFF;
    if (p < 32)  return (one << p) - one;
    return ~((one << (p - 32)) - one);
  endfunction

  task automatic chk_out(input string tag, input int ph, input int dl, input int acc);
    chk_eq({tag, "_valid"}, 32'(valid), 32'd1);
    chk_eq({tag, "_phase"}, 32'(phase), 32'(ph));
    chk_eq({tag, "_delta"}, 32'(phase_delta), 32'(dl));
    chk_eq({tag, "_acc"},   32'(phase_acc), 32'(acc));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n      = 1'b0;
    en         = 1'b0;
    osc_phases = '0;
    tick(2);
    chk_eq("rst_phase",    32'(phase), 32'd0);
    chk_eq("rst_delta",    32'(phase_delta), 32'd0);
    chk_eq("rst_acc",      32'(phase_acc), 32'd0);
    chk_eq("rst_valid",    32'(valid), 32'd0);
    chk_eq("rst_code_err", 32'(code_err), 32'd0);
    chk_eq("rst_err_cnt",  32'(err_cnt), 32'd0);

    // Constant phase 8; first valid after the 4th edge with en=1.
    rst_n      = 1'b1;
    en         = 1'b1;
    osc_phases = 32'h0000_00FF;
    tick(1);
    chk_eq("lat_e1_valid", 32'(valid), 32'd0);
    tick(2);
    chk_eq("lat_e3_valid", 32'(valid), 32'd0);
    tick(1);
    chk_out("first", 8, 0, 0);
    chk_eq("first_code_err", 32'(code_err), 32'd0);
    tick(1);
    chk_out("steady", 8, 0, 0);

    // Phase step 8 -> 40.
    osc_phases = 32'hFFFF_FF00;
    tick(4);
    chk_out("step40", 40, 32, 32);
    tick(1);
    chk_out("hold40", 40, 0, 32);

    // 40 -> 63 -> 2 (wrap of the phase circle).
    osc_phases = 32'h8000_0000;
    tick(4);
    chk_out("step63", 63, 23, 55);
    tick(1);
    osc_phases = 32'h0000_0003;
    tick(4);
    chk_out("wrap2", 2, 3, 58);

    // Stream of +3 steps long enough to wrap the accumulator:
    // 58 + 3*21846 = 65596 -> 60 mod 2^16; final phase (2+65538) mod 64 = 4.
    for (int i = 1; i <= N_STEPS; i++) begin
      osc_phases = enc((2 + 3 * i) % 64);
      tick(1);
    end
    tick(3);
    chk_out("accwrap", 4, 3, 60);
    tick(1);
    chk_eq("accwrap_hold_delta", 32'(phase_delta), 32'd0);

    // Single-cycle bubble word 0xF7 (popcount 7, three transitions).
    osc_phases = 32'h0000_00F7;
    tick(1);
    osc_phases = enc(10);
    tick(3);
    chk_eq("bubble_code_err", 32'(code_err), 32'd1);
    chk_eq("bubble_err_cnt",  32'(err_cnt), 32'd1);
`ifdef TDC_ERR_HOLD_EN
    chk_out("bubble", 4, 0, 60);
`else
    chk_out("bubble", 7, 3, 63);
`endif
    tick(1);
    chk_eq("post_bubble_code_err", 32'(code_err), 32'd0);
    chk_eq("post_bubble_err_cnt",  32'(err_cnt), 32'd1);
`ifdef TDC_ERR_HOLD_EN
    chk_out("post_bubble", 10, 6, 66);
`else
    chk_out("post_bubble", 10, 3, 66);
`endif
    tick(2);

    // en low for 5 cycles while the taps move to phase 40.
    en         = 1'b0;
    osc_phases = 32'hFFFF_FF00;
    tick(3);
    chk_out("en_drain", 10, 0, 66);
    tick(2);
    chk_eq("en_off_valid", 32'(valid), 32'd0);
    chk_eq("en_off_phase", 32'(phase), 32'd10);
    chk_eq("en_off_acc",   32'(phase_acc), 32'd66);
    en = 1'b1;
    tick(3);
    chk_eq("reen_e3_valid", 32'(valid), 32'd0);
    chk_eq("reen_e3_phase", 32'(phase), 32'd10);
    tick(1);
    chk_out("reen_first", 40, 0, 66);
    tick(1);
    chk_out("reen_next", 40, 0, 66);

    // Asynchronous reset between edges with a full valid pipeline.
    #3;
    rst_n = 1'b0;
    #1;
    chk_eq("arst_phase",    32'(phase), 32'd0);
    chk_eq("arst_delta",    32'(phase_delta), 32'd0);
    chk_eq("arst_acc",      32'(phase_acc), 32'd0);
    chk_eq("arst_valid",    32'(valid), 32'd0);
    chk_eq("arst_code_err", 32'(code_err), 32'd0);
    chk_eq("arst_err_cnt",  32'(err_cnt), 32'd0);

    // Release with a persistently bad code word: 300 error samples.
    osc_phases = 32'h0000_00F7;
    en         = 1'b1;
    #1;
    rst_n = 1'b1;
    tick(3);
    chk_eq("rel_e3_valid", 32'(valid), 32'd0);
    tick(1);
    chk_eq("rel_e4_code_err", 32'(code_err), 32'd1);
    chk_eq("rel_e4_err_cnt",  32'(err_cnt), 32'd1);
`ifdef TDC_ERR_HOLD_EN
    chk_out("rel_e4", 0, 0, 0);
`else
    chk_out("rel_e4", 7, 0, 0);
`endif
    tick(253);
    chk_eq("errcnt_254", 32'(err_cnt), 32'd254);
    tick(1);
    chk_eq("errcnt_255", 32'(err_cnt), 32'd255);
    tick(45);
    chk_eq("errcnt_sat", 32'(err_cnt), 32'd255);
    chk_eq("errcnt_sat_code_err", 32'(code_err), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
